// File: rtl/pipeline_control_unit_pkg.sv
// Shared definitions for the pipeline control unit, the forwarding unit and the debug unit.
// Holds the state encoding, the HALT opcode and the default widths.
package pipeline_control_unit_pkg;

  localparam int unsigned REG_BITS_DEF     = 5;
  localparam int unsigned CNT_WIDTH_DEF    = 32;
  localparam int unsigned DRAIN_CYCLES_DEF = 3;

  localparam logic [5:0] OP_HALT = 6'b111111;

  typedef enum logic [1:0] {
    RUN    = 2'b00,
    DRAIN  = 2'b01,
    HALTED = 2'b10
  } pcu_state_e;

endpackage

// File: rtl/pipeline_control_unit_load_use_detector.sv
// Flags a load in EX whose destination is read by the instruction in ID.
// Register 0 never creates a hazard because it is hardwired to zero.
module load_use_detector
  import pipeline_control_unit_pkg::*;
#(
  parameter int unsigned REG_BITS = REG_BITS_DEF
) (
  input  logic                id_ex_mem_read,
  input  logic [REG_BITS-1:0] id_ex_rt,
  input  logic [REG_BITS-1:0] if_id_rs,
  input  logic [REG_BITS-1:0] if_id_rt,
  input  logic                if_id_uses_rt,
  output logic                lu_hazard
);

  logic rs_match;
  logic rt_match;

  always_comb begin
    rs_match  = (id_ex_rt == if_id_rs);
    rt_match  = if_id_uses_rt && (id_ex_rt == if_id_rt);
    lu_hazard = id_ex_mem_read && (id_ex_rt != '0) && (rs_match || rt_match);
  end

endmodule

// File: rtl/pipeline_control_unit.sv
// Pipeline sequencer: load-use stalls, branch flush, halt drain and debug single-step.
// Control outputs are decoded combinationally so a hazard stalls in the cycle it appears.
module pipeline_control_unit
  import pipeline_control_unit_pkg::*;
#(
  parameter int unsigned REG_BITS     = REG_BITS_DEF,
  parameter int unsigned CNT_WIDTH    = CNT_WIDTH_DEF,
  parameter int unsigned DRAIN_CYCLES = DRAIN_CYCLES_DEF
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 id_ex_mem_read,
  input  logic [REG_BITS-1:0]  id_ex_rt,
  input  logic [REG_BITS-1:0]  if_id_rs,
  input  logic [REG_BITS-1:0]  if_id_rt,
  input  logic                 if_id_uses_rt,
  input  logic                 branch_taken,
  input  logic                 if_id_halt,
  input  logic                 step_mode,
  input  logic                 step,
  output logic                 pc_write,
  output logic                 if_id_write,
  output logic                 if_id_flush,
  output logic                 id_ex_bubble,
  output logic                 pipe_enable,
  output logic                 halted,
  output logic [CNT_WIDTH-1:0] cycle_count,
  output logic [CNT_WIDTH-1:0] stall_count
);

  localparam int unsigned DW = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;

  pcu_state_e      state;
  logic [DW-1:0]   drain_cnt;
  logic            lu_hazard;
  logic            adv;

  load_use_detector #(
    .REG_BITS(REG_BITS)
  ) u_lud (
    .id_ex_mem_read(id_ex_mem_read),
    .id_ex_rt      (id_ex_rt),
    .if_id_rs      (if_id_rs),
    .if_id_rt      (if_id_rt),
    .if_id_uses_rt (if_id_uses_rt),
    .lu_hazard     (lu_hazard)
  );

  always_comb begin
    adv          = !step_mode || step;
    pc_write     = 1'b0;
    if_id_write  = 1'b0;
    if_id_flush  = 1'b0;
    id_ex_bubble = 1'b0;
    pipe_enable  = 1'b0;
    halted       = (state == HALTED);
    if (adv) begin
      case (state)
        RUN: begin
          pipe_enable = 1'b1;
          if (lu_hazard) begin
            id_ex_bubble = 1'b1;
          end else if (branch_taken) begin
            pc_write    = 1'b1;
            if_id_write = 1'b1;
            if_id_flush = 1'b1;
          end else if (if_id_halt) begin
            if_id_write = 1'b1;
            if_id_flush = 1'b1;
          end else begin
            pc_write    = 1'b1;
            if_id_write = 1'b1;
          end
        end
        // ID holds a NOP while draining, so hazard and branch inputs are ignored
        DRAIN: begin
          pipe_enable = 1'b1;
          if_id_write = 1'b1;
          if_id_flush = 1'b1;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= RUN;
      drain_cnt   <= '0;
      cycle_count <= '0;
      stall_count <= '0;
    end else begin
      if (pipe_enable) begin
        cycle_count <= cycle_count + CNT_WIDTH'(1);
      end
      if (adv) begin
        case (state)
          RUN: begin
            if (lu_hazard) begin
              stall_count <= stall_count + CNT_WIDTH'(1);
            end else if (!branch_taken && if_id_halt) begin
              drain_cnt <= DW'(DRAIN_CYCLES - 1);
              state     <= DRAIN;
            end
          end
          DRAIN: begin
            if (drain_cnt == '0) begin
              state <= HALTED;
            end else begin
              drain_cnt <= drain_cnt - DW'(1);
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_pipeline_control_unit.sv
// Directed bench for pipeline_control_unit with a scoreboard of expected control/counter values.
// A second instance with 4-bit counters exercises counter wrap on the same stimulus.
module tb_pipeline_control_unit;

  logic       clk;
  logic       reset_n;
  logic       id_ex_mem_read;
  logic [4:0] id_ex_rt;
  logic [4:0] if_id_rs;
  logic [4:0] if_id_rt;
  logic       if_id_uses_rt;
  logic       branch_taken;
  logic       if_id_halt;
  logic       step_mode;
  logic       step;

  logic        pc_write, if_id_write, if_id_flush, id_ex_bubble, pipe_enable, halted;
  logic [31:0] cycle_count, stall_count;
  logic        n_pc_write, n_if_id_write, n_if_id_flush, n_id_ex_bubble, n_pipe_enable, n_halted;
  logic [3:0]  n_cycle_count, n_stall_count;

  int unsigned total  = 0;
  int unsigned passed = 0;
  logic [31:0] exp_cycles = '0;
  logic [31:0] exp_stall  = '0;

  // control vector order: {pc_write, if_id_write, if_id_flush, id_ex_bubble, pipe_enable, halted}
  localparam logic [5:0] IDLE  = 6'b110010;
  localparam logic [5:0] STALL = 6'b000110;
  localparam logic [5:0] BRF   = 6'b111010;
  localparam logic [5:0] HLT   = 6'b011010;
  localparam logic [5:0] DRN   = 6'b011010;
  localparam logic [5:0] OFF   = 6'b000000;
  localparam logic [5:0] HALTD = 6'b000001;

  typedef struct packed {
    logic [5:0]  ctl;
    logic [31:0] cyc;
    logic [31:0] stl;
  } exp_t;

  exp_t sb[$];

  pipeline_control_unit #(
    .REG_BITS(5), .CNT_WIDTH(32), .DRAIN_CYCLES(3)
  ) dut (
    .clk(clk), .reset_n(reset_n),
    .id_ex_mem_read(id_ex_mem_read), .id_ex_rt(id_ex_rt),
    .if_id_rs(if_id_rs), .if_id_rt(if_id_rt), .if_id_uses_rt(if_id_uses_rt),
    .branch_taken(branch_taken), .if_id_halt(if_id_halt),
    .step_mode(step_mode), .step(step),
    .pc_write(pc_write), .if_id_write(if_id_write), .if_id_flush(if_id_flush),
    .id_ex_bubble(id_ex_bubble), .pipe_enable(pipe_enable), .halted(halted),
    .cycle_count(cycle_count), .stall_count(stall_count)
  );

  pipeline_control_unit #(
    .REG_BITS(5), .CNT_WIDTH(4), .DRAIN_CYCLES(3)
  ) u_narrow (
    .clk(clk), .reset_n(reset_n),
    .id_ex_mem_read(id_ex_mem_read), .id_ex_rt(id_ex_rt),
    .if_id_rs(if_id_rs), .if_id_rt(if_id_rt), .if_id_uses_rt(if_id_uses_rt),
    .branch_taken(branch_taken), .if_id_halt(if_id_halt),
    .step_mode(step_mode), .step(step),
    .pc_write(n_pc_write), .if_id_write(n_if_id_write), .if_id_flush(n_if_id_flush),
    .id_ex_bubble(n_id_ex_bubble), .pipe_enable(n_pipe_enable), .halted(n_halted),
    .cycle_count(n_cycle_count), .stall_count(n_stall_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
  endtask

  task automatic set_in(input logic mr, input logic [4:0] ert, input logic [4:0] rs,
                        input logic [4:0] rt, input logic urt, input logic br,
                        input logic hlt, input logic sm, input logic st);
    id_ex_mem_read = mr;
    id_ex_rt       = ert;
    if_id_rs       = rs;
    if_id_rt       = rt;
    if_id_uses_rt  = urt;
    branch_taken   = br;
    if_id_halt     = hlt;
    step_mode      = sm;
    step           = st;
  endtask

  // Called at posedge+1: drive, push expectation, compare at negedge, return at next posedge+1.
  task automatic cyc(input string name, input logic mr, input logic [4:0] ert,
                     input logic [4:0] rs, input logic [4:0] rt, input logic urt,
                     input logic br, input logic hlt, input logic sm, input logic st,
                     input logic [5:0] o);
    exp_t e;
    exp_t got;
    set_in(mr, ert, rs, rt, urt, br, hlt, sm, st);
    e.ctl = o;
    e.cyc = exp_cycles;
    e.stl = exp_stall;
    sb.push_back(e);
    if (o[1]) exp_cycles = exp_cycles + 32'd1;
    if (o[2]) exp_stall  = exp_stall + 32'd1;
    @(negedge clk);
    got = sb.pop_front();
    chk({name, ".ctl"}, {26'd0, pc_write, if_id_write, if_id_flush, id_ex_bubble,
                         pipe_enable, halted}, {26'd0, got.ctl});
    chk({name, ".cycles"}, cycle_count, got.cyc);
    chk({name, ".stalls"}, stall_count, got.stl);
    chk({name, ".n_ctl"}, {26'd0, n_pc_write, n_if_id_write, n_if_id_flush, n_id_ex_bubble,
                           n_pipe_enable, n_halted}, {26'd0, got.ctl});
    chk({name, ".n_cycles"}, {28'd0, n_cycle_count}, {28'd0, got.cyc[3:0]});
    chk({name, ".n_stalls"}, {28'd0, n_stall_count}, {28'd0, got.stl[3:0]});
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input string name);
    set_in(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    #2 reset_n = 1'b0;
    #1;
    chk({name, ".ctl"}, {26'd0, pc_write, if_id_write, if_id_flush, id_ex_bubble,
                         pipe_enable, halted}, {26'd0, IDLE});
    chk({name, ".cycles"}, cycle_count, 32'd0);
    chk({name, ".stalls"}, stall_count, 32'd0);
    chk({name, ".n_cycles"}, {28'd0, n_cycle_count}, 32'd0);
    exp_cycles = '0;
    exp_stall  = '0;
    @(posedge clk);
    #1 reset_n = 1'b1;
  endtask

  initial begin
    reset_n = 1'b0;
    set_in(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    do_reset("por");

    //        name        mr ert  rs    rt    urt br hlt sm st  expect
    cyc("idle0",      0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 0, 0, IDLE);
    cyc("lu_rs",      1, 5'd5, 5'd5, 5'd1, 0, 0, 0, 0, 0, STALL);
    cyc("lu_clear",   0, 5'd5, 5'd5, 5'd1, 0, 0, 0, 0, 0, IDLE);
    cyc("no_r0",      1, 5'd0, 5'd0, 5'd0, 1, 0, 0, 0, 0, IDLE);
    cyc("no_rt_unused", 1, 5'd7, 5'd3, 5'd7, 0, 0, 0, 0, 0, IDLE);
    cyc("lu_rt",      1, 5'd7, 5'd3, 5'd7, 1, 0, 0, 0, 0, STALL);
    cyc("prio_lu_br", 1, 5'd5, 5'd5, 5'd0, 0, 1, 0, 0, 0, STALL);
    cyc("branch",     0, 5'd5, 5'd5, 5'd0, 0, 1, 0, 0, 0, BRF);
    cyc("idle1",      0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 0, 0, IDLE);

    for (int i = 0; i < 5; i++)
      cyc("step_low", 0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 1, 0, OFF);
    chk("step_low.frozen", cycle_count, 32'd9);
    for (int i = 0; i < 3; i++) begin
      cyc("step_pulse", 0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 1, 1, IDLE);
      cyc("step_gap",   0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 1, 0, OFF);
    end
    chk("step_pulse.count", cycle_count, 32'd12);
    cyc("step_lu",    1, 5'd5, 5'd5, 5'd0, 0, 0, 0, 1, 1, STALL);

    while (exp_cycles < 32'd17)
      cyc("fill", 0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 0, 0, IDLE);
    chk("wrap17.narrow", {28'd0, n_cycle_count}, 32'd1);
    chk("wrap17.wide", cycle_count, 32'd17);

    cyc("step_halt",  0, 5'd0, 5'd0, 5'd0, 0, 0, 1, 1, 1, HLT);
    for (int i = 0; i < 3; i++) begin
      cyc("sdrain_gap", 0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 1, 0, OFF);
      cyc("sdrain",     1, 5'd5, 5'd5, 5'd5, 1, 1, 0, 1, 1, DRN);
    end
    cyc("shalted_step", 0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 1, 1, HALTD);
    cyc("shalted_run",  0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 0, 0, HALTD);
    cyc("shalted_br",   1, 5'd5, 5'd5, 5'd0, 0, 1, 1, 0, 0, HALTD);
    do_reset("rst_halted");

    cyc("mid_halt",   0, 5'd0, 5'd0, 5'd0, 0, 0, 1, 0, 0, HLT);
    cyc("mid_drain",  0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 0, 0, DRN);
    do_reset("rst_drain");
    cyc("after_rst",  0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 0, 0, IDLE);

    cyc("halt_lu_first", 1, 5'd4, 5'd4, 5'd0, 0, 0, 1, 0, 0, STALL);
    cyc("halt",       0, 5'd0, 5'd0, 5'd0, 0, 0, 1, 0, 0, HLT);
    for (int i = 0; i < 3; i++)
      cyc("drain",    0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 0, 0, DRN);
    cyc("halted0",    0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 0, 0, HALTD);
    cyc("halted1",    0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 0, 0, HALTD);
    chk("halted.cycles", cycle_count, 32'd6);
    chk("halted.stalls", stall_count, 32'd1);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/pipeline_control_unit.md
Name: pipeline_control_unit

Overview:
- Sequences the 5-stage MIPS pipeline: load-use stall insertion, branch/jump flush of IF/ID, halt drain, and debug single-step gating.
- Sits beside the forwarding unit and the hazard-free datapath. Drives the PC/IF-ID write enables, the ID/EX bubble mux and the global pipeline enable.
- Exports cycle and stall counters to the debug unit.

Parameters:
- REG_BITS, 5, register-index width.
- CNT_WIDTH, 32, width of cycle_count and stall_count.
- DRAIN_CYCLES, 3, cycles after HALT leaves ID until it has retired in WB.

Ports:
- clk  in  1  pipeline clock; all state on rising edge.
- reset_n  in  1  asynchronous active-low reset.
- id_ex_mem_read  in  1  instruction in EX is a load.
- id_ex_rt  in  REG_BITS  load destination in EX.
- if_id_rs  in  REG_BITS  rs of instruction in ID.
- if_id_rt  in  REG_BITS  rt of instruction in ID.
- if_id_uses_rt  in  1  ID instruction reads rt as a source (R-type, branch, store).
- branch_taken  in  1  branch/jump resolved taken in ID this cycle.
- if_id_halt  in  1  HALT opcode decoded in ID.
- step_mode  in  1  debug single-step mode enabled.
- step  in  1  one-cycle pulse; advance pipeline one clock in step mode.
- pc_write  out  1  PC load enable.
- if_id_write  out  1  IF/ID register load enable.
- if_id_flush  out  1  load NOP into IF/ID.
- id_ex_bubble  out  1  zero all control bits entering ID/EX.
- pipe_enable  out  1  global enable for all pipeline registers and register-file/memory writes.
- halted  out  1  program retired; pipeline frozen.
- cycle_count  out  CNT_WIDTH  clocks with pipe_enable=1 since reset.
- stall_count  out  CNT_WIDTH  load-use bubbles inserted since reset.

Behaviour:
- Reset (async, reset_n=0):
  - state=RUN, drain_cnt=0, counters=0, halted=0.
  - Control outputs take their RUN idle values: pc_write=1, if_id_write=1, flush=0, bubble=0, pipe_enable=1 (gated by step rules).
  - Reset asserted mid-drain or in HALTED returns to RUN immediately.
- adv = !step_mode || step.
  - When adv=0: pipe_enable=0, pc_write=0, if_id_write=0, flush=0, bubble=0, no state/counter change.
  - All rules below apply only when adv=1.
- lu_hazard (combinational) = id_ex_mem_read && id_ex_rt!=0 && (id_ex_rt==if_id_rs || (if_id_uses_rt && id_ex_rt==if_id_rt)).
- Output decode is combinational from state and inputs, with zero latency, so a hazard in cycle N stalls in cycle N.
- State RUN:
  - lu_hazard: pc_write=0, if_id_write=0, id_ex_bubble=1, flush=0. stall_count+1. Remain RUN.
    - The hazard self-clears next cycle because the bubble occupies EX.
  - else branch_taken: pc_write=1 (target), if_id_flush=1.
  - else if_id_halt: pc_write=0, if_id_write=1, if_id_flush=1 (HALT moves to EX, NOP behind it). drain_cnt<=DRAIN_CYCLES-1, go DRAIN.
  - Priority: lu_hazard > branch_taken > if_id_halt. A deferred branch/halt is re-evaluated next cycle when it is still in ID.
- State DRAIN:
  - pc_write=0, if_id_flush=1, bubble=0. Hazard/branch inputs are ignored because ID holds a NOP.
  - drain_cnt decrements each advancing clock. At drain_cnt==0 go HALTED.
- State HALTED:
  - pipe_enable=0, pc_write=0, if_id_write=0, halted=1.
  - Counters frozen. Exit only by reset.
- cycle_count increments on every clock with pipe_enable=1, including stall and drain cycles. Both counters wrap modulo 2^CNT_WIDTH.
- In step mode, a step pulse while a hazard is present consumes that step as the bubble cycle.

Decomposition:
- Shared package:
  - state encoding RUN=2'b00, DRAIN=2'b01, HALTED=2'b10;
  - HALT opcode constant;
  - REG_BITS and CNT_WIDTH defaults (shared with the forwarding unit and debug unit).
- One sub-module: load_use_detector (pure combinational lu_hazard), reusable by the verification model.
- FSM, drain counter and the two statistics counters stay in the top.

Test Plan:
- Load-use: lw $5 in EX (id_ex_mem_read=1, id_ex_rt=5), ID rs=5 -> same cycle pc_write=0, if_id_write=0, id_ex_bubble=1; stall_count 0->1; next cycle with mem_read=0, outputs back to 1/1/0.
- No false stall: id_ex_rt=0 with rs=0, and id_ex_rt=7 with rt=7 but if_id_uses_rt=0 -> no bubble, stall_count unchanged.
- Priority: lu_hazard=1 and branch_taken=1 same cycle -> bubble=1, flush=0. Next cycle branch_taken=1 alone -> if_id_flush=1, pc_write=1.
- Halt: if_id_halt=1 in RUN -> flush=1, pc_write=0. Exactly DRAIN_CYCLES=3 clocks later halted=1, pipe_enable=0. cycle_count then frozen; reset_n pulse low async -> RUN, counters 0.
- Step mode: step_mode=1, step low for 5 clocks -> pipe_enable=0, cycle_count unchanged. Three single-clock step pulses -> cycle_count +3, and a halt in ID with step pulses completes drain only after 3 further steps.
- Counter wrap: CNT_WIDTH=4, run 17 enabled clocks -> cycle_count=1.
